seq_div_32: RTL and testbench

//  Multi-cycle 32-bit integer divider for the ALU datapath. Reverse operation of the
//  32-bit ripple-carry add/sub unit: it reuses one subtract per cycle (restoring

---
 rtl/seq_div_32.sv | 132 +++++++++++++
 tb/tb_seq_div_32.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div_32.sv
// Purpose: restoring 32-bit divider, one trial subtract per cycle; quotient, remainder, divide-by-zero flag.
// Latency: DONE WIDTH+1 cycles after the START edge (WIDTH+2 with SEQ_DIV_SIGNED_EN), 1 cycle for DVS==0.
// Backpressure: START is accepted only in IDLE with DONE low; requests while busy are dropped, not queued.
// Optional feature: define SEQ_DIV_SIGNED_EN for two's complement operands (adds a FIXUP state).
module seq_div_32 #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] DVD,
  input  logic [WIDTH-1:0] DVS,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             BUSY,
  output logic             DONE,
  output logic             DIV0
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIXUP, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] dvdOrig;
  logic [CW-1:0]    count;
  logic             isDiv0;
`ifdef SEQ_DIV_SIGNED_EN
  logic             negQuo;
  logic             negRem;
`endif

  // The shifted partial remainder can need WIDTH+1 bits when the divisor is large,
  // so the compare is done at that width; the difference itself always fits WIDTH bits.
  logic [WIDTH:0]   shifted;
  logic             noBorrow;
  logic [WIDTH-1:0] diff;

  // One restoring-division step: shift in the next dividend bit and trial-subtract.
  always_comb begin
    shifted  = {remReg, quoReg[WIDTH-1]};
    noBorrow = (shifted >= {1'b0, divisor});
    diff     = shifted[WIDTH-1:0] - divisor;
  end

  // Control FSM with registered outputs; Q/R/DIV0 only ever change when leaving FIN.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      divisor <= '0;
      remReg  <= '0;
      quoReg  <= '0;
      dvdOrig <= '0;
      count   <= '0;
      isDiv0  <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      negQuo  <= 1'b0;
      negRem  <= 1'b0;
`endif
      Q       <= '0;
      R       <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      DIV0    <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          // DONE is still high in the first IDLE cycle; a START there is dropped.
          if (START && !DONE) begin
            dvdOrig <= DVD;
            remReg  <= '0;
            count   <= CW'(WIDTH - 1);
            isDiv0  <= (DVS == '0);
`ifdef SEQ_DIV_SIGNED_EN
            divisor <= DVS[WIDTH-1] ? -DVS : DVS;
            quoReg  <= DVD[WIDTH-1] ? -DVD : DVD;
            negQuo  <= DVD[WIDTH-1] ^ DVS[WIDTH-1];
            negRem  <= DVD[WIDTH-1];
`else
            divisor <= DVS;
            quoReg  <= DVD;
`endif
            if (DVS == '0) begin
              state <= FIN;
            end else begin
              state <= RUN;
              BUSY  <= 1'b1;
            end
          end
        end
        RUN: begin
          remReg <= noBorrow ? diff : shifted[WIDTH-1:0];
          quoReg <= {quoReg[WIDTH-2:0], noBorrow};
          count  <= count - CW'(1);
          if (count == '0) begin
`ifdef SEQ_DIV_SIGNED_EN
            state <= FIXUP;
`else
            state <= FIN;
            BUSY  <= 1'b0;
`endif
          end
        end
`ifdef SEQ_DIV_SIGNED_EN
        FIXUP: begin
          // Quotient truncates toward zero; remainder follows the dividend's sign.
          if (negQuo) quoReg <= -quoReg;
          if (negRem) remReg <= -remReg;
          state <= FIN;
          BUSY  <= 1'b0;
        end
`endif
        FIN: begin
          Q     <= isDiv0 ? '1 : quoReg;
          R     <= isDiv0 ? dvdOrig : remReg;
          DIV0  <= isDiv0;
          DONE  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_32.sv
`timescale 1ns/1ps
module tb_seq_div_32;

  localparam int WIDTH = 32;
`ifdef SEQ_DIV_SIGNED_EN
  localparam int LAT = WIDTH + 2;
`else
  localparam int LAT = WIDTH + 1;
`endif

  logic        CLK   = 1'b0;
  logic        RST   = 1'b0;
  logic        START = 1'b0;
  logic [31:0] DVD   = '0;
  logic [31:0] DVS   = '0;
  logic [31:0] Q;
  logic [31:0] R;
  logic        BUSY;
  logic        DONE;
  logic        DIV0;

  int nAssert = 0;
  int nFail   = 0;

  seq_div_32 #(.WIDTH(WIDTH)) dut (
    .CLK(CLK), .RST(RST), .START(START), .DVD(DVD), .DVS(DVS),
    .Q(Q), .R(R), .BUSY(BUSY), .DONE(DONE), .DIV0(DIV0)
  );

  always #5 CLK = ~CLK;

  // Reference: plain arithmetic division with the divide-by-zero and overflow rules.
  function automatic void refDiv(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output logic d0);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; d0 = 1'b1;
    end else begin
      d0 = 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
`else
      q = a / b;
      r = a % b;
`endif
    end
  endfunction

  // Present one request for a single cycle, then scramble the operand inputs.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    START = 1'b1; DVD = a; DVS = b;
    @(negedge CLK);
    START = 1'b0; DVD = $urandom; DVS = $urandom;
  endtask

  // Count cycles from the START edge until DONE, and how many of them had BUSY high.
  task automatic waitDone(output int cyc, output int busyCnt);
    cyc = 0; busyCnt = 0;
    while (DONE !== 1'b1 && cyc < 200) begin
      if (BUSY === 1'b1) busyCnt++;
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic test_reset();
    int sawDone;
    repeat (2) @(negedge CLK);
    nAssert++; if (Q !== 32'd0)  begin nFail++; $display("FAIL reset_q got %h want 0", Q); end
    nAssert++; if (R !== 32'd0)  begin nFail++; $display("FAIL reset_r got %h want 0", R); end
    nAssert++; if (BUSY !== 1'b0) begin nFail++; $display("FAIL reset_busy got %b want 0", BUSY); end
    nAssert++; if (DONE !== 1'b0) begin nFail++; $display("FAIL reset_done got %b want 0", DONE); end
    nAssert++; if (DIV0 !== 1'b0) begin nFail++; $display("FAIL reset_div0 got %b want 0", DIV0); end
    RST = 1'b1;
    // Abort an operation mid-run.
    issue(32'd100, 32'd7);
    repeat (9) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    nAssert++; if (Q !== 32'd0 || R !== 32'd0) begin nFail++; $display("FAIL abort_qr got %h/%h want 0/0", Q, R); end
    nAssert++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin nFail++; $display("FAIL abort_flags got busy=%b done=%b want 0/0", BUSY, DONE); end
    @(negedge CLK);
    RST = 1'b1;
    sawDone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (DONE === 1'b1 || BUSY === 1'b1) sawDone++;
    end
    nAssert++; if (sawDone !== 0) begin nFail++; $display("FAIL abort_no_done got %0d active cycles want 0", sawDone); end
  endtask

  task automatic test_basic();
    int cyc, bc;
    issue(32'd100, 32'd7);
    waitDone(cyc, bc);
    nAssert++; if (cyc !== LAT) begin nFail++; $display("FAIL basic_latency got %0d want %0d", cyc, LAT); end
    nAssert++; if (bc !== LAT - 1) begin nFail++; $display("FAIL basic_busy_cycles got %0d want %0d", bc, LAT - 1); end
    nAssert++; if (Q !== 32'd14 || R !== 32'd2) begin nFail++; $display("FAIL basic_qr got %0d/%0d want 14/2", Q, R); end
    nAssert++; if (DIV0 !== 1'b0 || BUSY !== 1'b0) begin nFail++; $display("FAIL basic_flags got div0=%b busy=%b want 0/0", DIV0, BUSY); end
    @(negedge CLK);
    nAssert++; if (DONE !== 1'b0) begin nFail++; $display("FAIL basic_done_pulse got %b want 0", DONE); end
  endtask

  task automatic test_extremes();
    int cyc, bc;
    issue(32'hFFFF_FFFF, 32'd1);
    waitDone(cyc, bc);
`ifdef SEQ_DIV_SIGNED_EN
    // -1 / 1 in two's complement
    nAssert++; if (Q !== 32'hFFFF_FFFF || R !== 32'd0) begin nFail++; $display("FAIL ext_max_qr got %h/%h want ffffffff/0", Q, R); end
`else
    nAssert++; if (Q !== 32'hFFFF_FFFF || R !== 32'd0) begin nFail++; $display("FAIL ext_max_qr got %h/%h want ffffffff/0", Q, R); end
`endif
    issue(32'd5, 32'd9);
    waitDone(cyc, bc);
    nAssert++; if (Q !== 32'd0 || R !== 32'd5) begin nFail++; $display("FAIL ext_small_qr got %0d/%0d want 0/5", Q, R); end
    nAssert++; if (cyc !== LAT) begin nFail++; $display("FAIL ext_latency got %0d want %0d", cyc, LAT); end
  endtask

  task automatic test_div0();
    int cyc, bc;
    issue(32'd1234, 32'd0);
    waitDone(cyc, bc);
    nAssert++; if (cyc !== 1) begin nFail++; $display("FAIL div0_latency got %0d want 1", cyc); end
    nAssert++; if (Q !== 32'hFFFF_FFFF || R !== 32'd1234) begin nFail++; $display("FAIL div0_qr got %h/%0d want ffffffff/1234", Q, R); end
    nAssert++; if (DIV0 !== 1'b1) begin nFail++; $display("FAIL div0_flag got %b want 1", DIV0); end
    nAssert++; if (bc !== 0) begin nFail++; $display("FAIL div0_busy got %0d want 0", bc); end
  endtask

  // Runs right after test_div0, so the held result is ffffffff/1234.
  task automatic test_ignore();
    int cyc, stray;
    issue(32'd100, 32'd7);
    repeat (4) @(negedge CLK);
    START = 1'b1; DVD = 32'd50; DVS = 32'd5;
    @(negedge CLK);
    START = 1'b0;
    nAssert++; if (Q !== 32'hFFFF_FFFF || R !== 32'd1234) begin nFail++; $display("FAIL ign_hold_run got %h/%0d want ffffffff/1234", Q, R); end
    cyc = 5;
    while (DONE !== 1'b1 && cyc < 200) begin @(negedge CLK); cyc++; end
    nAssert++; if (cyc !== LAT) begin nFail++; $display("FAIL ign_latency got %0d want %0d", cyc, LAT); end
    nAssert++; if (Q !== 32'd14 || R !== 32'd2) begin nFail++; $display("FAIL ign_qr got %0d/%0d want 14/2", Q, R); end
    // Request on the DONE cycle must be dropped too.
    START = 1'b1; DVD = 32'd50; DVS = 32'd5;
    @(negedge CLK);
    START = 1'b0;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      if (BUSY === 1'b1 || DONE === 1'b1) stray++;
      @(negedge CLK);
    end
    nAssert++; if (stray !== 0) begin nFail++; $display("FAIL ign_done_cycle got %0d active cycles want 0", stray); end
    nAssert++; if (Q !== 32'd14 || R !== 32'd2) begin nFail++; $display("FAIL ign_stable got %0d/%0d want 14/2", Q, R); end
  endtask

  task automatic test_random();
    int cyc, bc, sel;
    logic [31:0] a, b, eq, er;
    logic ed;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if (b == 32'd0 && sel != 0) b = 32'd3;
      refDiv(a, b, eq, er, ed);
      issue(a, b);
      waitDone(cyc, bc);
      nAssert++;
      if (Q !== eq || R !== er || DIV0 !== ed)
        begin nFail++; $display("FAIL rand_%0d %h/%h got q=%h r=%h d0=%b want q=%h r=%h d0=%b", i, a, b, Q, R, DIV0, eq, er, ed); end
      nAssert++;
      if (cyc !== (ed ? 1 : LAT))
        begin nFail++; $display("FAIL rand_lat_%0d got %0d want %0d", i, cyc, ed ? 1 : LAT); end
    end
  endtask

`ifdef SEQ_DIV_SIGNED_EN
  task automatic test_signed();
    int cyc, bc;
    issue(-32'sd7, 32'sd2);
    waitDone(cyc, bc);
    nAssert++; if (Q !== 32'hFFFF_FFFD || R !== 32'hFFFF_FFFF) begin nFail++; $display("FAIL sgn_m7_2 got %h/%h want fffffffd/ffffffff", Q, R); end
    nAssert++; if (cyc !== 34) begin nFail++; $display("FAIL sgn_latency got %0d want 34", cyc); end
    issue(32'sd7, -32'sd2);
    waitDone(cyc, bc);
    nAssert++; if (Q !== 32'hFFFF_FFFD || R !== 32'd1) begin nFail++; $display("FAIL sgn_7_m2 got %h/%h want fffffffd/1", Q, R); end
    issue(32'h8000_0000, 32'hFFFF_FFFF);
    waitDone(cyc, bc);
    nAssert++; if (Q !== 32'h8000_0000 || R !== 32'd0 || DIV0 !== 1'b0) begin nFail++; $display("FAIL sgn_ovf got %h/%h d0=%b want 80000000/0 d0=0", Q, R, DIV0); end
    issue(-32'sd9, 32'd0);
    waitDone(cyc, bc);
    nAssert++; if (Q !== 32'hFFFF_FFFF || R !== 32'hFFFF_FFF7 || DIV0 !== 1'b1) begin nFail++; $display("FAIL sgn_div0 got %h/%h d0=%b want ffffffff/fffffff7 d0=1", Q, R, DIV0); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_div0();
    test_ignore();
    test_random();
`ifdef SEQ_DIV_SIGNED_EN
    test_signed();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
